// File: rtl/instr_encoder_loader.sv
// Program loader: encodes instruction field bundles into 32-bit MIPS words and
// writes them to consecutive instruction-memory addresses, one word per accepted bundle.
module instr_encoder_loader #(
    parameter int ADDR_W = 8,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic              last,
    output logic              mem_we,
    output logic [ADDR_W+1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err_op
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int AW    = ADDR_W + 2;
    localparam int CW    = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [5:0] o);
        logic ok;
        case (o)
            6'h00, 6'h23, 6'h2B, 6'h04,
            6'h08, 6'h0A, 6'h0C, 6'h0D: ok = 1'b1;
            default:                    ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] encode(
        input logic [5:0]  o,
        input logic [4:0]  s,
        input logic [4:0]  t,
        input logic [4:0]  d,
        input logic [4:0]  sh,
        input logic [5:0]  f,
        input logic [15:0] im
    );
        logic [31:0] w;
        if (o == 6'h00) w = {o, s, t, d, sh, f};
        else            w = {o, s, t, im};
        return w;
    endfunction

    state_t state_q, state_d;

    // Words written this session; doubles as the write pointer.
    logic [CW-1:0]   ptr;
    logic            vld_p1;
    logic            err_p1;
    logic [AW-1:0]   addr_p1;
    logic [31:0]     wdata_p1;

    logic accept, legal, wr, at_cap, enter_load;

    assign in_ready   = (state_q == LOAD) && (ptr != CW'(DEPTH));
    assign accept     = in_valid && in_ready;
    assign legal      = op_legal(op);
    assign wr         = accept && legal;
    assign at_cap     = (ptr == CW'(DEPTH - 1));
    assign enter_load = start && (state_q != LOAD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (accept && (last || (legal && at_cap))) state_d = DONE;
            DONE:    if (start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Stage p1: registered write port, one cycle after accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr      <= '0;
            full     <= 1'b0;
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            addr_p1  <= AW'(BASE);
            wdata_p1 <= '0;
        end else begin
            vld_p1 <= wr;
            err_p1 <= accept && !legal;
            if (enter_load) begin
                ptr  <= '0;
                full <= 1'b0;
            end else if (wr) begin
                addr_p1  <= AW'(BASE) + {ptr[ADDR_W-1:0], 2'b00};
                wdata_p1 <= encode(op, rs, rt, rd, shamt, funct, imm);
                ptr      <= ptr + 1'b1;
                if (at_cap) full <= 1'b1;
            end
        end
    end

    assign mem_we    = vld_p1;
    assign mem_addr  = addr_p1;
    assign mem_wdata = wdata_p1;
    assign err_op    = err_p1;
    assign count     = ptr;
    assign busy      = (state_q == LOAD);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: a large (ADDR_W=8) and a small (ADDR_W=2) instance,
// a behavioural model checked every cycle, plus hand-computed literal expectations.
module tb_instr_encoder_loader;

    localparam int BASE = 0;
    localparam int D0   = 256;
    localparam int D1   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start_m, start_s, valid_m, valid_s, last;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;

    logic        rdy_m, we_m, busy_m, done_m, full_m, err_m;
    logic [9:0]  addr_m;
    logic [31:0] wd_m;
    logic [8:0]  cnt_m;
    logic        rdy_s, we_s, busy_s, done_s, full_s, err_s;
    logic [3:0]  addr_s;
    logic [31:0] wd_s;
    logic [2:0]  cnt_s;

    instr_encoder_loader #(.ADDR_W(8), .BASE(BASE)) dut_m (
        .clk(clk), .reset_n(reset_n), .start(start_m), .in_valid(valid_m), .in_ready(rdy_m),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm), .last(last),
        .mem_we(we_m), .mem_addr(addr_m), .mem_wdata(wd_m), .count(cnt_m),
        .busy(busy_m), .done(done_m), .full(full_m), .err_op(err_m)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE(BASE)) dut_s (
        .clk(clk), .reset_n(reset_n), .start(start_s), .in_valid(valid_s), .in_ready(rdy_s),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm), .last(last),
        .mem_we(we_s), .mem_addr(addr_s), .mem_wdata(wd_s), .count(cnt_s),
        .busy(busy_s), .done(done_s), .full(full_s), .err_op(err_s)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit legal_op(input logic [5:0] o);
        return o inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0A, 6'h0C, 6'h0D};
    endfunction

    function automatic logic [31:0] enc_word();
        longint w;
        w = longint'(op) * (64'd1 << 26) + longint'(rs) * (64'd1 << 21) + longint'(rt) * (64'd1 << 16);
        if (op == 6'd0) w = w + longint'(rd) * 2048 + longint'(shamt) * 64 + longint'(funct);
        else            w = w + longint'(imm);
        return w[31:0];
    endfunction

    function automatic int depth_of(input int i);
        return (i == 0) ? D0 : D1;
    endfunction

    bit          m_ld[2], m_dn[2], m_fl[2], m_we[2], m_err[2];
    int          m_n[2];
    logic [31:0] m_addr[2], m_wd[2];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                m_ld[i] = 0; m_dn[i] = 0; m_fl[i] = 0; m_we[i] = 0; m_err[i] = 0;
                m_n[i] = 0; m_addr[i] = BASE; m_wd[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit st, v, acc;
                st  = (i == 0) ? start_m : start_s;
                v   = (i == 0) ? valid_m : valid_s;
                acc = v && m_ld[i] && (m_n[i] < depth_of(i));
                m_we[i]  = 0;
                m_err[i] = 0;
                if (!m_ld[i] && st) begin
                    m_ld[i] = 1; m_dn[i] = 0; m_n[i] = 0; m_fl[i] = 0;
                end else if (acc) begin
                    if (legal_op(op)) begin
                        m_we[i]   = 1;
                        m_addr[i] = (BASE + 4 * m_n[i]) % (4 * depth_of(i));
                        m_wd[i]   = enc_word();
                        m_n[i]    = m_n[i] + 1;
                        if (m_n[i] == depth_of(i)) begin
                            m_fl[i] = 1; m_ld[i] = 0; m_dn[i] = 1;
                        end
                    end else begin
                        m_err[i] = 1;
                    end
                    if (last) begin
                        m_ld[i] = 0; m_dn[i] = 1;
                    end
                end
            end
        end
    end

    task automatic cmp_inst(input int i, input logic rdy, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] cnt, input logic bsy,
                            input logic dn, input logic fl, input logic er);
        string p;
        p = (i == 0) ? "m" : "s";
        chk({p, ".in_ready"},  {31'd0, rdy}, {31'd0, (m_ld[i] && m_n[i] < depth_of(i))});
        chk({p, ".mem_we"},    {31'd0, we},  {31'd0, m_we[i]});
        chk({p, ".mem_addr"},  addr,         m_addr[i]);
        chk({p, ".mem_wdata"}, wd,           m_wd[i]);
        chk({p, ".count"},     cnt,          m_n[i]);
        chk({p, ".busy"},      {31'd0, bsy}, {31'd0, m_ld[i]});
        chk({p, ".done"},      {31'd0, dn},  {31'd0, m_dn[i]});
        chk({p, ".full"},      {31'd0, fl},  {31'd0, m_fl[i]});
        chk({p, ".err_op"},    {31'd0, er},  {31'd0, m_err[i]});
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_inst(0, rdy_m, we_m, 32'(addr_m), wd_m, 32'(cnt_m), busy_m, done_m, full_m, err_m);
            cmp_inst(1, rdy_s, we_s, 32'(addr_s), wd_s, 32'(cnt_s), busy_s, done_s, full_s, err_s);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                              input logic [4:0] d, input logic [4:0] sh, input logic [5:0] f,
                              input logic [15:0] im, input logic l);
        op = o; rs = s; rt = t; rd = d; shamt = sh; funct = f; imm = im; last = l;
    endtask

    task automatic send(input int which, input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [4:0] sh, input logic [5:0] f,
                        input logic [15:0] im, input logic l);
        set_fields(o, s, t, d, sh, f, im, l);
        if (which == 0) valid_m = 1'b1;
        else            valid_s = 1'b1;
        tick();
        valid_m = 1'b0;
        valid_s = 1'b0;
        last    = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1;
        start_m = 0; start_s = 0; valid_m = 0; valid_s = 0;
        set_fields(0, 0, 0, 0, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        cmp_en = 1'b1;
        tick(); tick();
        chk("rst.mem_addr", 32'(addr_m), BASE);
        chk("rst.in_ready", {31'd0, rdy_m}, 0);
        chk("rst.mem_wdata", wd_m, 0);
        reset_n = 1'b1;
        tick();

        // single R-type ADD, last
        start_m = 1; tick(); start_m = 0;
        chk("t1.in_ready", {31'd0, rdy_m}, 1);
        send(0, 6'h00, 1, 2, 3, 0, 6'h20, 16'h0, 1);
        chk("t1.mem_we", {31'd0, we_m}, 1);
        chk("t1.addr", 32'(addr_m), 0);
        chk("t1.wdata", wd_m, 32'h0022_1820);
        chk("t1.count", 32'(cnt_m), 1);
        tick();
        chk("t1.done", {31'd0, done_m}, 1);
        chk("t1.we_low", {31'd0, we_m}, 0);

        // LW then SW back-to-back
        start_m = 1; tick(); start_m = 0;
        chk("t2.count0", 32'(cnt_m), 0);
        send(0, 6'h23, 29, 8, 0, 0, 0, 16'h0004, 0);
        chk("t2.lw_wdata", wd_m, 32'h8FA8_0004);
        chk("t2.lw_addr", 32'(addr_m), 0);
        send(0, 6'h2B, 29, 8, 0, 0, 0, 16'h0008, 1);
        chk("t2.sw_we", {31'd0, we_m}, 1);
        chk("t2.sw_wdata", wd_m, 32'hAFA8_0008);
        chk("t2.sw_addr", 32'(addr_m), 4);
        chk("t2.count", 32'(cnt_m), 2);
        tick();

        // unsupported op mid-stream; start held high during LOAD
        start_m = 1; tick();
        send(0, 6'h08, 1, 2, 0, 0, 0, 16'h7FFF, 0);
        chk("t3.addi_wdata", wd_m, 32'h2022_7FFF);
        start_m = 0;
        send(0, 6'h02, 1, 2, 0, 0, 0, 16'h1234, 0);
        chk("t3.err_op", {31'd0, err_m}, 1);
        chk("t3.no_we", {31'd0, we_m}, 0);
        chk("t3.count_held", 32'(cnt_m), 1);
        chk("t3.wdata_held", wd_m, 32'h2022_7FFF);
        send(0, 6'h0D, 3, 4, 0, 0, 0, 16'hBEEF, 1);
        chk("t3.ori_addr", 32'(addr_m), 4);
        chk("t3.ori_wdata", wd_m, 32'h3464_BEEF);
        chk("t3.err_clr", {31'd0, err_m}, 0);
        tick();
        start_m = 1; tick(); start_m = 0;
        send(0, 6'h3F, 0, 0, 0, 0, 0, 16'h0, 1);
        chk("t3.bad_last_done", {31'd0, done_m}, 1);
        chk("t3.bad_last_cnt", 32'(cnt_m), 0);
        tick();

        // capacity on small instance
        start_s = 1; tick(); start_s = 0;
        for (int i = 0; i < 4; i++) begin
            send(1, 6'h0C, 5'(i), 5'(i), 0, 0, 0, 16'(i), 0);
            chk("t4.addr", 32'(addr_s), 32'(4 * i));
            chk("t4.we", {31'd0, we_s}, 1);
        end
        chk("t4.full", {31'd0, full_s}, 1);
        chk("t4.done", {31'd0, done_s}, 1);
        chk("t4.in_ready", {31'd0, rdy_s}, 0);
        send(1, 6'h0C, 9, 9, 0, 0, 0, 16'h9, 0);
        chk("t4.fifth_we", {31'd0, we_s}, 0);
        chk("t4.count", 32'(cnt_s), 4);
        chk("t4.addr_held", 32'(addr_s), 32'hC);

        // restart after DONE clears full and count
        start_s = 1; tick(); start_s = 0;
        chk("t6.full_clr", {31'd0, full_s}, 0);
        chk("t6.count_clr", 32'(cnt_s), 0);
        send(1, 6'h0C, 7, 9, 0, 0, 0, 16'h00FF, 0);
        chk("t6.addr", 32'(addr_s), BASE);
        chk("t6.wdata", wd_s, 32'h30E9_00FF);

        // reset right after an accept
        start_m = 1; tick(); start_m = 0;
        set_fields(6'h04, 5, 6, 0, 0, 0, 16'hFFFE, 0);
        valid_m = 1;
        @(posedge clk);
        #1 reset_n = 1'b0;
        valid_m = 0;
        #2;
        chk("t5.mem_we", {31'd0, we_m}, 0);
        chk("t5.busy", {31'd0, busy_m}, 0);
        chk("t5.count", 32'(cnt_m), 0);
        chk("t5.addr", 32'(addr_m), BASE);
        chk("t5.wdata", wd_m, 0);
        tick();
        reset_n = 1'b1;
        tick(); tick();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
